mdu_iter: RTL

- Iterative multiply/divide unit in the EX stage. It consumes the mul/div request that the single-cycle ALU issues (function, signedness, operands).
- Computes a 64-bit product or a quotient/remainder pair, one bit per cycle.
- Writes the result into HI/LO as a one-cycle write pulse.
- Stalls the pipeline while busy.

---
 rtl/mdu_iter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply or restoring
// divide, sign fix-up on completion, single-cycle HI/LO write pulse.
`ifndef FUNC_MUL
`define FUNC_MUL 5'b11000
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b11010
`endif

module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [4:0]      mulalu_func,
    input  logic            mulalu_sign,
    input  logic [XLEN-1:0] source_a,
    input  logic [XLEN-1:0] source_b,
    output logic            stall,
    output logic            hi_write,
    output logic [XLEN-1:0] hi_write_data,
    output logic            lo_write,
    output logic [XLEN-1:0] lo_write_data
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                is_div_q;
    logic                neg_quot_q;
    logic                neg_rem_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_d;

    logic                req;
    logic                req_div;
    logic [XLEN-1:0]     abs_a;
    logic [XLEN-1:0]     abs_b;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   product;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
        return n ? (~x + XLEN'(1)) : x;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide_if(input logic [2*XLEN-1:0] x, input logic n);
        return n ? (~x + (2*XLEN)'(1)) : x;
    endfunction

    assign req     = (mulalu_func == `FUNC_MUL) || (mulalu_func == `FUNC_DIV);
    assign req_div = (mulalu_func == `FUNC_DIV);
    assign abs_a   = neg_if(source_a, mulalu_sign & source_a[XLEN-1]);
    assign abs_b   = neg_if(source_b, mulalu_sign & source_b[XLEN-1]);

    // acc holds {hi, lo}: multiply shifts right adding into hi; divide shifts {rem, quot} left
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        if (is_div_q) begin
            if (div_diff[XLEN])
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            else
                acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else if (acc_q[0]) begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q    <= S_CALC;
                        cnt_q      <= '0;
                        is_div_q   <= req_div;
                        neg_quot_q <= mulalu_sign & (source_a[XLEN-1] ^ source_b[XLEN-1]);
                        neg_rem_q  <= mulalu_sign & source_a[XLEN-1];
                        opnd_q     <= req_div ? abs_b : abs_a;
                        acc_q      <= {{XLEN{1'b0}}, (req_div ? abs_a : abs_b)};
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST)
                        state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Divide by zero leaves quot all ones and rem = |a|; skipping quotient negation
    // then yields lo = all ones and hi = the raw dividend.
    always_comb begin
        stall         = 1'b0;
        hi_write      = 1'b0;
        lo_write      = 1'b0;
        hi_write_data = '0;
        lo_write_data = '0;
        product       = neg_wide_if(acc_q, neg_quot_q);
        if (!rst && !flush) begin
            case (state_q)
                S_IDLE: stall = req;
                S_CALC: stall = 1'b1;
                S_DONE: begin
                    hi_write = 1'b1;
                    lo_write = 1'b1;
                    if (is_div_q) begin
                        hi_write_data = neg_if(acc_q[2*XLEN-1:XLEN], neg_rem_q);
                        lo_write_data = (opnd_q == '0) ? '1
                                      : neg_if(acc_q[XLEN-1:0], neg_quot_q);
                    end else begin
                        hi_write_data = product[2*XLEN-1:XLEN];
                        lo_write_data = product[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
